// File: rtl/packet_collector.sv
// packet_collector: round-robin merge of NUM_LANES AXI-Stream lanes onto one output, whole packets per grant.
// Define PACKET_COLLECTOR_STATS_EN to add a saturating count of packets delivered on m_axis.
module packet_collector #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 2,
  localparam int NUM_LANES = 2 ** AXIS_DEST_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES*AXIS_DATA_WIDTH-1:0] s_axis_packet_collector_tdata,
  input  logic [NUM_LANES*AXIS_KEEP_WIDTH-1:0] s_axis_packet_collector_tkeep,
  input  logic [NUM_LANES-1:0]                 s_axis_packet_collector_tvalid,
  input  logic [NUM_LANES-1:0]                 s_axis_packet_collector_tlast,
  output logic [NUM_LANES-1:0]                 s_axis_packet_collector_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           m_axis_packet_collector_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_packet_collector_tkeep,
  output logic                                 m_axis_packet_collector_tvalid,
  output logic                                 m_axis_packet_collector_tlast,
  input  logic                                 m_axis_packet_collector_tready,
  output logic [AXIS_DEST_WIDTH-1:0]           m_axis_packet_collector_tid,
`ifdef PACKET_COLLECTOR_STATS_EN
  input  logic                                 w_rst_packet_counter,
  output logic [31:0]                          w_packet_counter,
`endif
  input  logic                                 w_enable_pc
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] FORWARD = 1'b1;

  logic [0:0]                 state;
  logic [AXIS_DEST_WIDTH-1:0] grant;
  logic [AXIS_DEST_WIDTH-1:0] rr_ptr;
  logic [AXIS_DEST_WIDTH-1:0] next_lane;
  logic [AXIS_DEST_WIDTH-1:0] cand;
  logic                       lane_found;
  logic                       out_free;
  logic                       s_accept;
  logic [AXIS_DATA_WIDTH-1:0] sel_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] sel_tkeep;
  logic                       sel_tvalid;
  logic                       sel_tlast;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !m_axis_packet_collector_tvalid || m_axis_packet_collector_tready;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lane_found = 1'b0;
    next_lane  = rr_ptr;
    cand       = rr_ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = rr_ptr + AXIS_DEST_WIDTH'(i);
      if (!lane_found && s_axis_packet_collector_tvalid[cand]) begin
        lane_found = 1'b1;
        next_lane  = cand;
      end
    end
  end

  assign sel_tdata  = s_axis_packet_collector_tdata[int'(grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign sel_tkeep  = s_axis_packet_collector_tkeep[int'(grant)*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
  assign sel_tvalid = s_axis_packet_collector_tvalid[grant];
  assign sel_tlast  = s_axis_packet_collector_tlast[grant];

  // Only the granted lane ever sees tready, which keeps packets atomic.
  always_comb begin
    s_axis_packet_collector_tready = '0;
    if (state == FORWARD) begin
      s_axis_packet_collector_tready[grant] = out_free;
    end
  end

  assign s_accept = (state == FORWARD) && sel_tvalid && out_free;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                          <= IDLE;
      grant                          <= '0;
      rr_ptr                         <= '0;
      m_axis_packet_collector_tvalid <= 1'b0;
      m_axis_packet_collector_tlast  <= 1'b0;
      m_axis_packet_collector_tdata  <= '0;
      m_axis_packet_collector_tkeep  <= '0;
      m_axis_packet_collector_tid    <= '0;
    end else begin
      if (state == IDLE) begin
        if (w_enable_pc && lane_found) begin
          grant <= next_lane;
          state <= FORWARD;
        end
      end else if (s_accept && sel_tlast) begin
        rr_ptr <= grant + AXIS_DEST_WIDTH'(1);
        state  <= IDLE;
      end

      if (s_accept) begin
        m_axis_packet_collector_tvalid <= 1'b1;
        m_axis_packet_collector_tlast  <= sel_tlast;
        m_axis_packet_collector_tdata  <= sel_tdata;
        m_axis_packet_collector_tkeep  <= sel_tkeep;
        m_axis_packet_collector_tid    <= grant;
      end else if (m_axis_packet_collector_tready) begin
        m_axis_packet_collector_tvalid <= 1'b0;
      end
    end
  end

`ifdef PACKET_COLLECTOR_STATS_EN
  logic pkt_done;

  assign pkt_done = m_axis_packet_collector_tvalid && m_axis_packet_collector_tready &&
                    m_axis_packet_collector_tlast;

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_packet_counter <= '0;
    end else if (w_rst_packet_counter) begin
      w_packet_counter <= '0;
    end else if (pkt_done && (w_packet_counter != 32'hFFFF_FFFF)) begin
      w_packet_counter <= w_packet_counter + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_collector.sv
// Bench for packet_collector: random packets per lane scored against per-lane expected queues and rotation order.
// Also covers the PACKET_COLLECTOR_STATS_EN counter when that macro is defined.
`timescale 1ns/1ps
module tb_packet_collector;
  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DESTW = 2;
  localparam int NL    = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NL*DW-1:0] s_tdata;
  logic [NL*KW-1:0] s_tkeep;
  logic [NL-1:0]    s_tvalid;
  logic [NL-1:0]    s_tlast;
  logic [NL-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [DESTW-1:0] m_tid;
  logic             w_enable_pc;
`ifdef PACKET_COLLECTOR_STATS_EN
  logic             w_rst_packet_counter;
  logic [31:0]      w_packet_counter;
`endif

  always #5 clk = ~clk;

  packet_collector #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_DEST_WIDTH(DESTW)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .s_axis_packet_collector_tdata  (s_tdata),
    .s_axis_packet_collector_tkeep  (s_tkeep),
    .s_axis_packet_collector_tvalid (s_tvalid),
    .s_axis_packet_collector_tlast  (s_tlast),
    .s_axis_packet_collector_tready (s_tready),
    .m_axis_packet_collector_tdata  (m_tdata),
    .m_axis_packet_collector_tkeep  (m_tkeep),
    .m_axis_packet_collector_tvalid (m_tvalid),
    .m_axis_packet_collector_tlast  (m_tlast),
    .m_axis_packet_collector_tready (m_tready),
    .m_axis_packet_collector_tid    (m_tid),
`ifdef PACKET_COLLECTOR_STATS_EN
    .w_rst_packet_counter           (w_rst_packet_counter),
    .w_packet_counter               (w_packet_counter),
`endif
    .w_enable_pc                    (w_enable_pc)
  );

  int errors = 0;
  int checks = 0;

  beat_t lane_q[NL][$];  // beats each source has yet to hand over
  beat_t exp_q[NL][$];   // beats each lane still owes the merged output
  int    pkt_order[$];   // source lane of every packet start seen on m_axis
  int    rdy_mode;       // 0 always ready, 1 toggling, 2 random, 3 never
  bit    toggle;
  int    in_lane;        // lane whose packet is part-way through the input side, -1 if none
  int    out_lane;       // lane whose packet is part-way through the output side, -1 if none
  int    cyc;
  int    first_valid_cyc;
  int    out_beats;
  logic            prev_stall;
  logic [DW-1:0]   prev_tdata;
  logic [KW-1:0]   prev_tkeep;
  logic            prev_tlast;
  logic [DESTW-1:0] prev_tid;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic present();
    for (int i = 0; i < NL; i++) begin
      if (lane_q[i].size() > 0) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = lane_q[i][0].data;
        s_tkeep[i*KW +: KW] = lane_q[i][0].keep;
        s_tlast[i]          = lane_q[i][0].last;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = {$urandom, $urandom};
        s_tkeep[i*KW +: KW] = KW'($urandom);
        s_tlast[i]          = 1'($urandom);
      end
    end
  endtask

  task automatic load_lane(input int lane, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      beat_t bt;
      bt.data = {$urandom, $urandom};
      bt.keep = ($urandom_range(0, 3) == 0) ? '0 : KW'($urandom);
      bt.last = (b == nbeats - 1);
      lane_q[lane].push_back(bt);
      exp_q[lane].push_back(bt);
    end
    present();
  endtask

  task automatic set_ready();
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: begin toggle = ~toggle; m_tready = toggle; end
      2: m_tready = 1'($urandom);
      default: m_tready = 1'b0;
    endcase
  endtask

  // One clock: check at the falling edge, then update sources just after the rising edge.
  task automatic cycle();
    logic [NL-1:0] acc;
    int            nrdy;
    beat_t         e;
    @(negedge clk);
    if (prev_stall) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== prev_tdata || m_tkeep !== prev_tkeep ||
          m_tlast !== prev_tlast || m_tid !== prev_tid) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b id=%0d, want v=1 d=%h k=%h l=%b id=%0d",
                 m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, prev_tdata, prev_tkeep, prev_tlast, prev_tid);
      end
    end
    nrdy = $countones(s_tready);
    checks++;
    if (nrdy > 1 || (in_lane >= 0 && nrdy == 1 && s_tready[in_lane] !== 1'b1)) begin
      errors++;
      $display("FAIL tready_owner: tready=%b, want at most the open lane %0d", s_tready, in_lane);
    end
    acc = s_tvalid & s_tready;
    if (m_tvalid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      out_beats++;
      checks++;
      if (out_lane >= 0 && int'(m_tid) != out_lane) begin
        errors++;
        $display("FAIL interleave: tid=%0d while packet from lane %0d open", m_tid, out_lane);
      end
      if (out_lane < 0) pkt_order.push_back(int'(m_tid));
      checks++;
      if (exp_q[m_tid].size() == 0) begin
        errors++;
        $display("FAIL spurious_beat: tid=%0d d=%h l=%b, want no beat", m_tid, m_tdata, m_tlast);
      end else begin
        e = exp_q[m_tid].pop_front();
        if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
          errors++;
          $display("FAIL beat_content: tid=%0d got d=%h k=%h l=%b, want d=%h k=%h l=%b",
                   m_tid, m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
        end
      end
      out_lane = (m_tlast === 1'b1) ? -1 : int'(m_tid);
    end
    prev_stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
    prev_tdata = m_tdata;
    prev_tkeep = m_tkeep;
    prev_tlast = m_tlast;
    prev_tid   = m_tid;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NL; i++) begin
      if (acc[i] && lane_q[i].size() > 0) begin
        e = lane_q[i].pop_front();
        in_lane = e.last ? -1 : i;
      end
    end
    present();
    set_ready();
  endtask

  function automatic bit drained();
    for (int i = 0; i < NL; i++)
      if (lane_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return (m_tvalid === 1'b0);
  endfunction

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while (!drained() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: not drained after %0d cycles, want drained", tag, budget);
    end
  endtask

  task automatic run_outs(input int k, input int budget, input string tag);
    int target = out_beats + k;
    int n = 0;
    while (out_beats < target && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (out_beats < target) begin
      errors++;
      $display("FAIL %s_outs_timeout: got %0d beats, want %0d", tag, out_beats, target);
    end
  endtask

  task automatic check_order(input string tag, input int exp_order[], input int n);
    int base = pkt_order.size() - n;
    checks++;
    if (base < 0) begin
      errors++;
      $display("FAIL %s_order_len: got %0d packets, want %0d", tag, pkt_order.size(), n);
      return;
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (pkt_order[base+k] != exp_order[k]) begin
        errors++;
        $display("FAIL %s_order[%0d]: got lane %0d, want lane %0d", tag, k, pkt_order[base+k], exp_order[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 ||
        m_tid !== '0 || s_tready !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b l=%b d=%h k=%h id=%0d rdy=%b, want all zero",
               m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid, s_tready);
    end
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_order[] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NL; i++) load_lane(i, 1);
    run_until_idle(200, "rr");
    load_lane(0, 1);
    run_until_idle(200, "rr_wrap");
    check_order("rr", exp_order, 5);
  endtask

  task automatic test_single_packet();
    int base_beats;
    int exp_order[] = '{2};
    m_tready = 1'b1;
    rdy_mode = 0;
    base_beats = out_beats;
    first_valid_cyc = -1;
    cyc = 0;
    load_lane(2, 3);
    run_until_idle(100, "single");
    checks++;
    if (first_valid_cyc != 2) begin
      errors++;
      $display("FAIL single_latency: first output at cycle %0d, want 2", first_valid_cyc);
    end
    checks++;
    if (out_beats - base_beats != 3) begin
      errors++;
      $display("FAIL single_beats: got %0d beats, want 3", out_beats - base_beats);
    end
    check_order("single", exp_order, 1);
  endtask

  task automatic test_backpressure();
    int base_beats = out_beats;
    rdy_mode = 1;
    toggle = 1'b0;
    m_tready = 1'b0;
    load_lane(1, 4);
    run_until_idle(200, "bp");
    checks++;
    if (out_beats - base_beats != 4) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats, want 4", out_beats - base_beats);
    end
    rdy_mode = 0;
    m_tready = 1'b1;
  endtask

  task automatic test_no_interleave();
    int exp_order[] = '{3, 0};
    load_lane(3, 4);
    run_outs(1, 50, "ilv");
    load_lane(0, 1);
    run_until_idle(200, "ilv");
    check_order("ilv", exp_order, 2);
  endtask

  task automatic test_mid_reset();
    int exp_order[] = '{0, 3};
    load_lane(2, 1);
    run_until_idle(100, "mrst_pre");
    load_lane(1, 5);
    run_outs(1, 50, "mrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NL; i++) begin
      lane_q[i].delete();
      exp_q[i].delete();
    end
    in_lane = -1;
    out_lane = -1;
    prev_stall = 1'b0;
    present();
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 ||
        m_tid !== '0 || s_tready !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: v=%b l=%b d=%h k=%h id=%0d rdy=%b, want all zero",
               m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid, s_tready);
    end
    repeat (4) cycle();
    load_lane(3, 1);
    load_lane(0, 1);
    run_until_idle(100, "mrst_post");
    check_order("mrst", exp_order, 2);
  endtask

  task automatic test_enable();
    int exp_order[] = '{1};
    load_lane(0, 3);
    run_outs(1, 50, "en");
    w_enable_pc = 1'b0;
    load_lane(1, 1);
    repeat (12) cycle();
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 1) begin
      errors++;
      $display("FAIL enable_hold: lane0 left=%0d lane1 left=%0d, want 0 and 1",
               exp_q[0].size(), exp_q[1].size());
    end
    w_enable_pc = 1'b1;
    run_until_idle(100, "en");
    check_order("en", exp_order, 1);
  endtask

  task automatic test_random();
    int start;
    int exp_order[];
    for (int round = 0; round < 3; round++) begin
      rdy_mode = round;
      start = (pkt_order[pkt_order.size()-1] + 1) % NL;
      for (int i = 0; i < NL; i++) begin
        load_lane(i, $urandom_range(1, 5));
        load_lane(i, $urandom_range(1, 5));
      end
      run_until_idle(3000, "rand");
      exp_order = new[2*NL];
      for (int k = 0; k < 2*NL; k++) exp_order[k] = (start + k) % NL;
      check_order("rand", exp_order, 2*NL);
    end
    rdy_mode = 2;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int lane = $urandom_range(0, NL-1);
        if (lane_q[lane].size() == 0) load_lane(lane, $urandom_range(1, 4));
      end
      cycle();
    end
    run_until_idle(2000, "rand_tail");
    rdy_mode = 0;
    m_tready = 1'b1;
  endtask

`ifdef PACKET_COLLECTOR_STATS_EN
  task automatic test_stats();
    w_rst_packet_counter = 1'b1;
    @(posedge clk);
    #1;
    w_rst_packet_counter = 1'b0;
    checks++;
    if (w_packet_counter !== 32'd0) begin
      errors++;
      $display("FAIL stats_clear: got %0d, want 0", w_packet_counter);
    end
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) load_lane(i, $urandom_range(1, 3));
    run_until_idle(200, "stats");
    checks++;
    if (w_packet_counter !== 32'd3) begin
      errors++;
      $display("FAIL stats_count: got %0d, want 3", w_packet_counter);
    end
    rdy_mode = 3;
    m_tready = 1'b0;
    load_lane(3, 1);
    repeat (4) cycle();
    m_tready = 1'b1;
    rdy_mode = 0;
    w_rst_packet_counter = 1'b1;
    cycle();
    w_rst_packet_counter = 1'b0;
    checks++;
    if (w_packet_counter !== 32'd0 || exp_q[3].size() != 0) begin
      errors++;
      $display("FAIL stats_clear_wins: got %0d (lane3 left %0d), want 0 (0)", w_packet_counter, exp_q[3].size());
    end
    load_lane(2, 2);
    run_until_idle(100, "stats_after");
    checks++;
    if (w_packet_counter !== 32'd1) begin
      errors++;
      $display("FAIL stats_resume: got %0d, want 1", w_packet_counter);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    w_enable_pc = 1'b1;
`ifdef PACKET_COLLECTOR_STATS_EN
    w_rst_packet_counter = 1'b0;
`endif
    rdy_mode = 0;
    toggle = 1'b0;
    in_lane = -1;
    out_lane = -1;
    cyc = 0;
    first_valid_cyc = -1;
    out_beats = 0;
    prev_stall = 1'b0;
    prev_tdata = '0;
    prev_tkeep = '0;
    prev_tlast = 1'b0;
    prev_tid = '0;

    test_reset();
    test_round_robin();
    test_single_packet();
    test_backpressure();
    test_no_interleave();
    test_mid_reset();
    test_enable();
    test_random();
`ifdef PACKET_COLLECTOR_STATS_EN
    test_stats();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
